// File: rtl/regfile_bypass_sb.sv
// Parametrised register file: two bypassed combinational read ports, one write port, pending-write scoreboard.
// Optional macro RF_ZERO_REG_EN hardwires register 0 to zero and keeps its pending bit clear.
module regfile_bypass_sb #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] read1,
  input  logic [ADDR_W-1:0] read2,
  output logic [DATA_W-1:0] read_out1,
  output logic [DATA_W-1:0] read_out2,
  output logic              pending1,
  output logic              pending2,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              reg_write,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic [DEPTH-1:0]  pending_vec
);

`ifdef RF_ZERO_REG_EN
  localparam logic ZERO_REG = 1'b1;
`else
  localparam logic ZERO_REG = 1'b0;
`endif

  logic [DATA_W-1:0] rf [DEPTH];
  logic [DEPTH-1:0]  sb;
  logic              wr_en;

  function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
    return ZERO_REG && (a == '0);
  endfunction

  // A write asserted during reset must neither land nor bypass onto the read ports.
  assign wr_en = reg_write & reset_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
      sb <= '0;
    end else begin
      if (wr_en && !is_zero_reg(write_reg)) rf[write_reg] <= write_data;
      // New producer wins over a retiring write to the same index.
      for (int i = 0; i < DEPTH; i++) begin
        if (issue_valid && issue_reg == ADDR_W'(i) && !is_zero_reg(ADDR_W'(i)))
          sb[i] <= 1'b1;
        else if (wr_en && write_reg == ADDR_W'(i))
          sb[i] <= 1'b0;
      end
    end
  end

  function automatic logic hit(input logic [ADDR_W-1:0] a);
    return wr_en && (write_reg == a) && !is_zero_reg(a);
  endfunction

  always_comb begin
    read_out1 = rf[read1];
    if (is_zero_reg(read1))  read_out1 = '0;
    else if (hit(read1))     read_out1 = write_data;
  end

  always_comb begin
    read_out2 = rf[read2];
    if (is_zero_reg(read2))  read_out2 = '0;
    else if (hit(read2))     read_out2 = write_data;
  end

  assign pending1    = sb[read1] & ~hit(read1);
  assign pending2    = sb[read2] & ~hit(read2);
  assign pending_vec = sb;

endmodule
